// File: rtl/valid_flush_ctrl.sv
// Sweeps the cache valid memory and clears valid bits for one line (invalidate)
// or every line (flush); busy stalls the controller while a sweep runs.
module valid_flush_ctrl #(
   parameter int INDEX_LEN   = 8,
   parameter int NUM_CACHE_L = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush_req,
   input  logic                 inv_req,
   input  logic [INDEX_LEN-1:0] inv_index,
   output logic                 vm_rd,
   output logic [INDEX_LEN-1:0] vm_index,
   input  logic                 vm_valid,
   output logic                 vm_clr,
   output logic [INDEX_LEN-1:0] vm_clr_index,
   output logic                 busy,
   output logic                 done,
   output logic [INDEX_LEN:0]   inv_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CHECK,
      S_CLEAR,
      S_DONE
   } state_t;

   typedef enum logic {
      M_SINGLE,
      M_FLUSH
   } mode_t;

   localparam logic [INDEX_LEN-1:0] LAST_IDX = INDEX_LEN'(NUM_CACHE_L - 1);

   state_t               r_state;
   mode_t                r_mode;
   logic [INDEX_LEN-1:0] r_idx;
   logic                 r_vm_rd;
   logic [INDEX_LEN-1:0] r_vm_index;
   logic                 r_vm_clr;
   logic [INDEX_LEN-1:0] r_vm_clr_index;
   logic                 r_busy;
   logic                 r_done;
   logic [INDEX_LEN:0]   r_inv_count;

   logic                 w_last;
   logic [INDEX_LEN-1:0] w_idx_nxt;

   assign w_last    = (r_mode == M_SINGLE) || (r_idx == LAST_IDX);
   assign w_idx_nxt = r_idx + INDEX_LEN'(1);

   // Outputs are registered on entry to the state that owns them, so each
   // strobe is visible during that state's cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_mode         <= M_SINGLE;
         r_idx          <= '0;
         r_vm_rd        <= 1'b0;
         r_vm_index     <= '0;
         r_vm_clr       <= 1'b0;
         r_vm_clr_index <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_inv_count    <= '0;
      end else begin
         r_vm_rd  <= 1'b0;
         r_vm_clr <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (flush_req || inv_req) begin
                  r_mode      <= flush_req ? M_FLUSH : M_SINGLE;
                  r_idx       <= flush_req ? '0 : inv_index;
                  r_vm_index  <= flush_req ? '0 : inv_index;
                  r_vm_rd     <= 1'b1;
                  r_inv_count <= '0;
                  r_busy      <= 1'b1;
                  r_state     <= S_READ;
               end
            end
            S_READ: begin
               r_state <= S_CHECK;
            end
            S_CHECK: begin
               if (vm_valid) begin
                  r_vm_clr       <= 1'b1;
                  r_vm_clr_index <= r_idx;
                  r_inv_count    <= r_inv_count + (INDEX_LEN+1)'(1);
                  r_state        <= S_CLEAR;
               end else if (w_last) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx      <= w_idx_nxt;
                  r_vm_index <= w_idx_nxt;
                  r_vm_rd    <= 1'b1;
                  r_state    <= S_READ;
               end
            end
            S_CLEAR: begin
               if (w_last) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx      <= w_idx_nxt;
                  r_vm_index <= w_idx_nxt;
                  r_vm_rd    <= 1'b1;
                  r_state    <= S_READ;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign vm_rd        = r_vm_rd;
   assign vm_index     = r_vm_index;
   assign vm_clr       = r_vm_clr;
   assign vm_clr_index = r_vm_clr_index;
   assign busy         = r_busy;
   assign done         = r_done;
   assign inv_count    = r_inv_count;

endmodule

// File: tb/tb_valid_flush_ctrl.sv
// Scoreboard bench for valid_flush_ctrl on an 8-line cache with a behavioural
// valid memory; expected clears and done pulses are queued ahead of each request.
module tb_valid_flush_ctrl;

   localparam int IL = 3;
   localparam int NL = 8;

   typedef struct {
      int cyc;
      int cnt;
   } done_exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush_req;
   logic          inv_req;
   logic [IL-1:0] inv_index;
   logic          vm_rd;
   logic [IL-1:0] vm_index;
   logic          vm_valid;
   logic          vm_clr;
   logic [IL-1:0] vm_clr_index;
   logic          busy;
   logic          done;
   logic [IL:0]   inv_count;

   logic [NL-1:0] mem;
   logic          load;
   logic [NL-1:0] load_val;

   int        cyc = 0;
   int        checks = 0;
   int        errors = 0;
   int        exp_clr[$];
   done_exp_t exp_done[$];

   valid_flush_ctrl #(.INDEX_LEN(IL), .NUM_CACHE_L(NL)) dut (
      .clk(clk), .reset(reset), .flush_req(flush_req), .inv_req(inv_req),
      .inv_index(inv_index), .vm_rd(vm_rd), .vm_index(vm_index),
      .vm_valid(vm_valid), .vm_clr(vm_clr), .vm_clr_index(vm_clr_index),
      .busy(busy), .done(done), .inv_count(inv_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Valid memory: registered read data, clear at the edge.
   always @(posedge clk) begin
      if (load) mem <= load_val;
      else if (vm_clr) mem[vm_clr_index] <= 1'b0;
      if (vm_rd) vm_valid <= mem[vm_index];
   end

   // Monitor: pops expectations whenever the DUT presents a clear or done.
   always @(negedge clk) begin
      if (vm_clr) begin
         checks++;
         if (exp_clr.size() == 0) begin
            errors++;
            $display("FAIL unexpected_clr cyc=%0d got idx=%0d, required none", cyc, vm_clr_index);
         end else begin
            int e;
            e = exp_clr.pop_front();
            if (int'(vm_clr_index) != e) begin
               errors++;
               $display("FAIL clr_index cyc=%0d got %0d required %0d", cyc, vm_clr_index, e);
            end
         end
      end
      if (vm_clr && vm_rd) begin
         checks++;
         errors++;
         $display("FAIL rd_clr_overlap cyc=%0d got both high, required exclusive", cyc);
      end
      if (done) begin
         checks++;
         if (exp_done.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done cyc=%0d got done, required none", cyc);
         end else begin
            done_exp_t d;
            d = exp_done.pop_front();
            if (cyc != d.cyc || int'(inv_count) != d.cnt || !busy) begin
               errors++;
               $display("FAIL done cyc got %0d cnt %0d busy %0b, required cyc %0d cnt %0d busy 1",
                        cyc, inv_count, busy, d.cyc, d.cnt);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, got, req);
      end
   endtask

   task automatic issue(input bit f, input bit iv, input logic [IL-1:0] ix, output int t0);
      @(negedge clk);
      flush_req = f;
      inv_req   = iv;
      inv_index = ix;
      t0 = cyc;
      @(negedge clk);
      flush_req = 1'b0;
      inv_req   = 1'b0;
   endtask

   task automatic preload(input logic [NL-1:0] v);
      @(negedge clk);
      load = 1'b1;
      load_val = v;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_clr.size() != 0 || exp_done.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, exp_clr.size() + exp_done.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int t0;
      reset = 1'b1;
      flush_req = 1'b1;
      inv_req = 1'b0;
      inv_index = '0;
      load = 1'b1;
      load_val = '0;

      // Reset held 3 cycles with flush_req high; flush accepted right after.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_outputs", int'({vm_rd, vm_clr, busy, done}), 0);
         check("reset_values", int'({vm_index, vm_clr_index, inv_count}), 0);
      end
      t0 = cyc;
      exp_done.push_back('{t0 + 17, 0});
      reset = 1'b0;
      load = 1'b0;
      @(negedge clk);
      flush_req = 1'b0;
      check("post_reset_busy", int'(busy), 1);
      check("post_reset_rd_idx0", int'({vm_rd, vm_index}), 8);
      drain("reset_flush");

      // Single invalidate of a valid line: rd T1, clr T3, done T4.
      preload(8'b0010_0000);
      exp_clr.push_back(5);
      @(negedge clk);
      check("idle_busy", int'(busy), 0);
      issue(1'b0, 1'b1, 3'd5, t0);
      exp_done.push_back('{t0 + 4, 1});
      check("inv5_rd_T1", int'({vm_rd, vm_index}), 8 + 5);
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         check("inv5_busy", int'(busy), (k <= 4) ? 1 : 0);
      end
      drain("inv5");
      check("inv5_count_hold", int'(inv_count), 1);
      check("inv5_mem", int'(mem), 0);

      // Single invalidate of an invalid line: no clear, done T3.
      preload(8'b1111_1011);
      issue(1'b0, 1'b1, 3'd2, t0);
      exp_done.push_back('{t0 + 3, 0});
      check("inv2_rd_T1", int'({vm_rd, vm_index}), 8 + 2);
      drain("inv2");
      check("inv2_mem", int'(mem), 8'hFB);

      // Flush with lines {0,3,7} valid: done T20, count 3.
      preload(8'b1000_1001);
      exp_clr.push_back(0);
      exp_clr.push_back(3);
      exp_clr.push_back(7);
      issue(1'b1, 1'b0, 3'd0, t0);
      exp_done.push_back('{t0 + 20, 3});
      drain("flush_037");
      check("flush_037_mem", int'(mem), 0);
      check("flush_037_count", int'(inv_count), 3);

      // Both requests: flush wins; an inv_req pulsed mid-sweep is dropped.
      preload(8'b0101_0010);
      exp_clr.push_back(1);
      exp_clr.push_back(4);
      exp_clr.push_back(6);
      issue(1'b1, 1'b1, 3'd4, t0);
      exp_done.push_back('{t0 + 1 + 16 + 3, 3});
      repeat (4) @(negedge clk);
      inv_req = 1'b1;
      inv_index = 3'd6;
      @(negedge clk);
      inv_req = 1'b0;
      drain("both_req");
      check("both_req_mem", int'(mem), 0);

      // Reset at T6 of a flush over an all-valid cache.
      preload(8'hFF);
      exp_clr.push_back(0);
      exp_clr.push_back(1);
      issue(1'b1, 1'b0, 3'd0, t0);
      while (cyc < t0 + 6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_strobes", int'({vm_rd, vm_clr, done}), 0);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_quiet", exp_clr.size() + exp_done.size(), 0);
      check("abort_mem", int'(mem), 8'hFC);
      for (int i = 2; i < NL; i++) exp_clr.push_back(i);
      issue(1'b1, 1'b0, 3'd0, t0);
      exp_done.push_back('{t0 + 1 + 4 + 18, 6});
      drain("after_abort");
      check("after_abort_mem", int'(mem), 0);
      check("after_abort_count", int'(inv_count), 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no finish, required finish");
      $fatal(1);
   end

endmodule

// File: doc/valid_flush_ctrl.md
Name: valid_flush_ctrl

Overview:
- Sweeps the direct-mapped cache valid memory and clears valid bits, either one indexed line (invalidate) or every line (flush).
- Counterpart to the valid memory's set-on-fill path: the fill logic sets bits, this block reads them back and clears them.
- Sits between the cache controller (request side) and the valid memory's read port and clear port.
- Drives a busy flag so the controller stalls lookups while a sweep is in progress.

Parameters:
- INDEX_LEN, 8, cache index width.
- NUM_CACHE_L, 256, number of cache lines; must equal 2**INDEX_LEN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-high.
- flush_req  in  1  request to invalidate all lines; sampled only while idle.
- inv_req  in  1  request to invalidate one line; sampled only while idle.
- inv_index  in  INDEX_LEN  line index for inv_req; captured with the request.
- vm_rd  out  1  valid-memory read strobe.
- vm_index  out  INDEX_LEN  valid-memory read index.
- vm_valid  in  1  valid bit returned one cycle after vm_rd.
- vm_clr  out  1  clear strobe; clears valid_memory[vm_clr_index] at the clock edge.
- vm_clr_index  out  INDEX_LEN  index to clear.
- busy  out  1  high from the first cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle pulse when an operation completes.
- inv_count  out  INDEX_LEN+1  number of lines actually cleared by the last operation.

Behaviour:
- Reset: state=IDLE. vm_rd, vm_clr, busy and done are 0. vm_index, vm_clr_index and inv_count are 0. Internal index counter and mode are 0.
- Reset mid-operation aborts immediately. No vm_clr is issued after the reset edge, and no done pulse is generated.
- FSM states: IDLE, READ, CHECK, CLEAR, DONE.
- IDLE:
  - If flush_req=1: mode=FLUSH, idx=0.
  - Else if inv_req=1: mode=SINGLE, idx=inv_index.
  - Either way, inv_count is cleared and the next state is READ.
  - flush_req has priority when both requests are high. The losing inv_req is dropped, not queued.
- READ: vm_rd=1, vm_index=idx. Next state is CHECK.
- CHECK:
  - Sample vm_valid.
  - If 1: go to CLEAR.
  - Else, if last line: go to DONE.
  - Else: idx=idx+1, go to READ.
- CLEAR:
  - vm_clr=1, vm_clr_index=idx, inv_count=inv_count+1.
  - Then, if last line: go to DONE.
  - Else: idx=idx+1, go to READ.
- Last line means: SINGLE mode always; FLUSH mode when idx==NUM_CACHE_L-1. The index never wraps past the last line.
- DONE: done=1 for exactly one cycle. Next state is IDLE. busy is still 1 in this cycle.
- vm_rd and vm_clr are single-cycle strobes that are never high in the same cycle. vm_index and vm_clr_index hold their last value when their strobe is low.
- Requests arriving while busy=1, including in the DONE cycle, are ignored. The requester must hold its request until it sees busy=0.
- Timing, with the accept cycle as T0:
  - Each line costs 2 cycles if invalid, 3 if valid.
  - DONE occurs at T0 + 1 + sum of per-line costs.
  - Flush DONE cycle = T0 + 2*NUM_CACHE_L + (number of valid lines) + 1.
- inv_count holds its value after DONE until the next accepted request. A full flush of an all-valid cache yields inv_count=NUM_CACHE_L, which fits in INDEX_LEN+1 bits.

Test Plan:
- Reset held for 3 cycles while flush_req=1 -> all outputs 0, state IDLE. After release, the flush is accepted on the first non-reset edge.
- NUM_CACHE_L=8, line 5 valid, inv_req with inv_index=5 at T0 -> vm_rd T1 (index 5), vm_clr T3 (index 5), done T4, inv_count=1, busy T1–T4.
- inv_req with inv_index=2, line 2 invalid -> vm_rd T1, no vm_clr, done T3, inv_count=0.
- NUM_CACHE_L=8, valid lines {0,3,7}, flush_req at T0 -> vm_clr at indices 0, 3, 7 only, done T20, inv_count=3, all valid bits 0 afterwards.
- flush_req and inv_req (index 4) both high at T0 -> flush performed. A second inv_req pulsed during busy -> ignored, exactly one done.
- reset asserted at T6 of a flush -> next cycle IDLE, busy=0, no further vm_clr or done. A new flush then completes normally.
